// File: rtl/motor_sched_pkg.sv
// motor_sched_pkg: shared constants and FSM encoding for the motor setpoint
// scheduler (channel count, legal setpoint ceiling, default ramp step,
// speed/index widths, scheduler states).
package motor_sched_pkg;

  localparam int NUM_MOTOR_DEF = 6;
  localparam int MAX_VAL_DEF   = 999;
  localparam int STEP_DEF      = 10;
  localparam int SPD_W         = 10;
  localparam int IDX_W         = 3;

  typedef enum logic {
    IDLE = 1'b0,
    SEND = 1'b1
  } state_t;

endpackage

// File: rtl/motor_ramp_ch.sv
// motor_ramp_ch: one motor channel -- target and current speed registers,
// ramp toward the target on tick, dirty flag raised on any current change.
//   clk, rst   : clock, synchronous active-high reset
//   wr_en      : load wr_val into target
//   wr_val     : new target
//   tick       : ramp strobe
//   clr_dirty  : scheduler has snapshotted this channel
//   current    : current speed
//   dirty      : current changed since last snapshot
//   diff       : current != target
module motor_ramp_ch
  import motor_sched_pkg::*;
#(
  parameter int STEP = STEP_DEF
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             wr_en,
  input  logic [SPD_W-1:0] wr_val,
  input  logic             tick,
  input  logic             clr_dirty,
  output logic [SPD_W-1:0] current,
  output logic             dirty,
  output logic             diff
);

  localparam logic [SPD_W-1:0] STEP_V = SPD_W'(STEP);

  logic [SPD_W-1:0] target;
  logic [SPD_W-1:0] cur_nxt;

  // Ramp works on the distance to target so it can never overshoot or wrap.
  always_comb begin
    cur_nxt = current;
    if (tick) begin
      if (current < target)
        cur_nxt = (target - current > STEP_V) ? current + STEP_V : target;
      else if (current > target)
        cur_nxt = (current - target > STEP_V) ? current - STEP_V : target;
    end
  end

  // A change coinciding with a snapshot keeps dirty set so the newer value
  // is sent later.
  always_ff @(posedge clk) begin
    if (rst) begin
      target  <= '0;
      current <= '0;
      dirty   <= 1'b0;
    end else begin
      if (wr_en)
        target <= wr_val;
      current <= cur_nxt;
      if (cur_nxt != current)
        dirty <= 1'b1;
      else if (clr_dirty)
        dirty <= 1'b0;
    end
  end

  assign diff = (current != target);

endmodule

// File: rtl/motor_sched.sv
// motor_sched: per-motor setpoint ramping with a round-robin update scheduler.
//   clk, rst : clock, synchronous active-high reset
//   Value    : edited setpoint (0..MAX_VAL legal)
//   Motor    : edited motor index
//   Lock     : high while editing; falling edge commits Value to Motor
//   tick     : one-cycle ramp strobe
//   OutReady : downstream accepts the presented update
//   OutValid : update presented
//   OutMotor : index of presented update
//   OutSpeed : speed of presented update
//   Busy     : registered, any channel still ramping
module motor_sched
  import motor_sched_pkg::*;
#(
  parameter int NUM_MOTOR = NUM_MOTOR_DEF,
  parameter int STEP      = STEP_DEF,
  parameter int MAX_VAL   = MAX_VAL_DEF
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [SPD_W-1:0] Value,
  input  logic [IDX_W-1:0] Motor,
  input  logic             Lock,
  input  logic             tick,
  input  logic             OutReady,
  output logic             OutValid,
  output logic [IDX_W-1:0] OutMotor,
  output logic [SPD_W-1:0] OutSpeed,
  output logic             Busy
);

  logic             lock_q;
  logic             commit_q;
  logic [SPD_W-1:0] cval_q;
  logic [IDX_W-1:0] cmot_q;
  logic             commit_ok;

  logic [NUM_MOTOR-1:0] wr_en;
  logic [NUM_MOTOR-1:0] clr;
  logic [NUM_MOTOR-1:0] dirty;
  logic [NUM_MOTOR-1:0] diff;
  logic [SPD_W-1:0]     current [NUM_MOTOR];

  state_t           state, state_nxt;
  logic [IDX_W-1:0] rr_ptr;
  logic             pick_found;
  logic [IDX_W-1:0] pick_idx;
  logic             load;
  int unsigned      ci;
  logic [IDX_W-1:0] cidx;

  // Edit commit: the fall is detected against the registered Lock and the
  // edit is captured then; the target write lands on the following edge.
  always_ff @(posedge clk) begin
    if (rst) begin
      lock_q   <= 1'b0;
      commit_q <= 1'b0;
      cval_q   <= '0;
      cmot_q   <= '0;
    end else begin
      lock_q   <= Lock;
      commit_q <= lock_q & ~Lock;
      if (lock_q & ~Lock) begin
        cval_q <= Value;
        cmot_q <= Motor;
      end
    end
  end

  assign commit_ok = commit_q && (int'(cmot_q) < NUM_MOTOR) && (int'(cval_q) <= MAX_VAL);

  for (genvar g = 0; g < NUM_MOTOR; g++) begin : g_ch
    assign wr_en[g] = commit_ok && (cmot_q == IDX_W'(g));

    motor_ramp_ch #(
      .STEP(STEP)
    ) u_ch (
      .clk      (clk),
      .rst      (rst),
      .wr_en    (wr_en[g]),
      .wr_val   (cval_q),
      .tick     (tick),
      .clr_dirty(clr[g]),
      .current  (current[g]),
      .dirty    (dirty[g]),
      .diff     (diff[g])
    );
  end

  // First dirty channel at or after rr_ptr, wrapping at NUM_MOTOR-1.
  always_comb begin
    pick_found = 1'b0;
    pick_idx   = '0;
    ci         = 0;
    cidx       = '0;
    for (int unsigned k = 0; k < NUM_MOTOR; k++) begin
      ci = int'(rr_ptr) + k;
      if (ci >= NUM_MOTOR)
        ci = ci - NUM_MOTOR;
      cidx = IDX_W'(ci);
      if (!pick_found && dirty[cidx]) begin
        pick_found = 1'b1;
        pick_idx   = cidx;
      end
    end
  end

  always_comb begin
    state_nxt = state;
    clr       = '0;
    load      = 1'b0;
    case (state)
      IDLE: begin
        if (pick_found) begin
          state_nxt     = SEND;
          load          = 1'b1;
          clr[pick_idx] = 1'b1;
        end
      end
      SEND: begin
        if (OutReady)
          state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= IDLE;
      rr_ptr   <= '0;
      OutMotor <= '0;
      OutSpeed <= '0;
      Busy     <= 1'b0;
    end else begin
      state <= state_nxt;
      Busy  <= |diff;
      if (load) begin
        OutMotor <= pick_idx;
        OutSpeed <= current[pick_idx];
      end
      if (state == SEND && OutReady)
        rr_ptr <= (OutMotor == IDX_W'(NUM_MOTOR - 1)) ? '0 : OutMotor + 1'b1;
    end
  end

  assign OutValid = (state == SEND);

endmodule
